// File: rtl/fsm_q2_onehot_seq.sv
// Registered one-hot A-F sequencer. Exposes next-state bits Y1/Y3, Moore output z,
// a saturating run length of z, and recovers to A from any non-one-hot state.
module fsm_q2_onehot_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             w,
    input  logic             load,
    input  logic [5:0]       load_val,
    input  logic             clr_err,
    output logic [5:0]       y,
    output logic             Y1,
    output logic             Y3,
    output logic             z,
    output logic             err,
    output logic [CNT_W-1:0] z_run
);
    // state | meaning
    // A     | idle / home, also the recovery target
    // B     | first w=1 seen from A
    // C     | second step of a w=1 run
    // D     | w=0 seen after leaving A
    // E     | sustained w=1 run, z asserted
    // F     | w=1 from D, z asserted
    localparam logic [5:0] ST_A = 6'b000001;
    localparam logic [5:0] ST_B = 6'b000010;
    localparam logic [5:0] ST_C = 6'b000100;
    localparam logic [5:0] ST_D = 6'b001000;
    localparam logic [5:0] ST_E = 6'b010000;
    localparam logic [5:0] ST_F = 6'b100000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [5:0]       y_next;
    logic [5:0]       y_m1;
    logic [5:0]       lv_m1;
    logic             y_illegal;
    logic             lv_legal;
    logic [CNT_W-1:0] z_run_inc;

    // Bitwise next vector, valid for any y so Y1/Y3 track it even when corrupted.
    always_comb begin
        y_next    = '0;
        y_next[0] = (|(y & (ST_A | ST_D))) & ~w;
        y_next[1] = (|(y & ST_A)) & w;
        y_next[2] = (|(y & (ST_B | ST_F))) & w;
        y_next[3] = (|(y & (ST_B | ST_C | ST_E | ST_F))) & ~w;
        y_next[4] = (|(y & (ST_C | ST_E))) & w;
        y_next[5] = (|(y & ST_D)) & w;
    end

    assign Y1 = y_next[1];
    assign Y3 = y_next[3];
    assign z  = |(y & (ST_E | ST_F));

    assign y_m1      = y - 6'd1;
    assign lv_m1     = load_val - 6'd1;
    assign y_illegal = (y == '0) || ((y & y_m1) != '0);
    assign lv_legal  = (load_val != '0) && ((load_val & lv_m1) == '0);
    assign z_run_inc = (z_run == CNT_MAX) ? z_run : z_run + CNT_ONE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y     <= ST_A;
            z_run <= '0;
        end else if (y_illegal) begin
            y     <= ST_A;
            z_run <= '0;
        end else if (load) begin
            y     <= load_val;
            z_run <= (lv_legal && (load_val[4] | load_val[5])) ? z_run_inc : '0;
        end else if (en) begin
            y     <= y_next;
            z_run <= (y_next[4] | y_next[5]) ? z_run_inc : '0;
        end
    end

    // Set has priority over clear so a coincident clr_err cannot hide a fresh fault.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (y_illegal) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_q2_onehot_seq.sv
// Scoreboard bench for fsm_q2_onehot_seq: directed vectors push expected results,
// a monitor pops and compares one entry after each clock edge. Two widths checked.
module tb_fsm_q2_onehot_seq;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_val = '0;
    logic       clr_err = 1'b0;

    logic [5:0] y_w8, y_w2;
    logic       y1_w8, y1_w2, y3_w8, y3_w2, z_w8, z_w2, err_w8, err_w2;
    logic [7:0] zr_w8;
    logic [1:0] zr_w2;

    typedef struct packed {
        logic [5:0] y;
        logic       z;
        logic       y1;
        logic       y3;
        logic       err;
        logic [1:0] zr2;
        logic [7:0] zr8;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fsm_q2_onehot_seq #(.CNT_W(8)) dut8 (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .load(load), .load_val(load_val),
        .clr_err(clr_err), .y(y_w8), .Y1(y1_w8), .Y3(y3_w8), .z(z_w8), .err(err_w8),
        .z_run(zr_w8)
    );

    fsm_q2_onehot_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .load(load), .load_val(load_val),
        .clr_err(clr_err), .y(y_w2), .Y1(y1_w2), .Y3(y3_w2), .z(z_w2), .err(err_w2),
        .z_run(zr_w2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("y_w8", 32'(y_w8), 32'(e.y));
        chk("z_w8", 32'(z_w8), 32'(e.z));
        chk("Y1_w8", 32'(y1_w8), 32'(e.y1));
        chk("Y3_w8", 32'(y3_w8), 32'(e.y3));
        chk("err_w8", 32'(err_w8), 32'(e.err));
        chk("z_run_w8", 32'(zr_w8), 32'(e.zr8));
        chk("y_w2", 32'(y_w2), 32'(e.y));
        chk("z_w2", 32'(z_w2), 32'(e.z));
        chk("Y1_w2", 32'(y1_w2), 32'(e.y1));
        chk("Y3_w2", 32'(y3_w2), 32'(e.y3));
        chk("err_w2", 32'(err_w2), 32'(e.err));
        chk("z_run_w2", 32'(zr_w2), 32'(e.zr2));
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic e_i, input logic w_i, input logic l_i,
                        input logic [5:0] lv_i, input logic c_i,
                        input logic [5:0] ey, input logic ez, input logic ey1,
                        input logic ey3, input logic eerr,
                        input logic [1:0] ezr2, input logic [7:0] ezr8);
        exp_t e;
        @(negedge clk);
        en = e_i; w = w_i; load = l_i; load_val = lv_i; clr_err = c_i;
        e.y = ey; e.z = ez; e.y1 = ey1; e.y3 = ey3; e.err = eerr;
        e.zr2 = ezr2; e.zr8 = ezr8;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin : stim
        exp_t r;
        #12;
        r = '{y: 6'h01, z: 1'b0, y1: 1'b0, y3: 1'b0, err: 1'b0, zr2: 2'd0, zr8: 8'd0};
        chk_all(r);
        @(negedge clk);
        resetn = 1'b1;

        //    en w  ld lv     clr  y      z  Y1 Y3 err zr2 zr8
        step(0, 0, 0, 6'h00, 0,   6'h01, 0, 0, 0, 0,  0,  0);
        step(0, 0, 0, 6'h00, 0,   6'h01, 0, 0, 0, 0,  0,  0);
        step(0, 0, 0, 6'h00, 0,   6'h01, 0, 0, 0, 0,  0,  0);
        step(0, 1, 0, 6'h00, 0,   6'h01, 0, 1, 0, 0,  0,  0);
        // w=1 run from A
        step(1, 1, 0, 6'h00, 0,   6'h02, 0, 0, 0, 0,  0,  0);
        step(1, 1, 0, 6'h00, 0,   6'h04, 0, 0, 0, 0,  0,  0);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  1,  1);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  2,  2);
        // E -> D -> F -> C -> E -> D -> A
        step(0, 0, 0, 6'h00, 0,   6'h10, 1, 0, 1, 0,  2,  2);
        step(1, 0, 0, 6'h00, 0,   6'h08, 0, 0, 0, 0,  0,  0);
        step(1, 1, 0, 6'h00, 0,   6'h20, 1, 0, 0, 0,  1,  1);
        step(1, 1, 0, 6'h00, 0,   6'h04, 0, 0, 0, 0,  0,  0);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  1,  1);
        step(1, 0, 0, 6'h00, 0,   6'h08, 0, 0, 0, 0,  0,  0);
        step(1, 0, 0, 6'h00, 0,   6'h01, 0, 0, 0, 0,  0,  0);
        // illegal loads, recovery, sticky err and clear
        step(1, 0, 1, 6'h03, 0,   6'h03, 0, 0, 1, 0,  0,  0);
        step(1, 0, 0, 6'h00, 0,   6'h01, 0, 0, 0, 1,  0,  0);
        step(0, 1, 0, 6'h00, 1,   6'h01, 0, 1, 0, 0,  0,  0);
        step(1, 0, 1, 6'h00, 0,   6'h00, 0, 0, 0, 0,  0,  0);
        step(0, 0, 0, 6'h00, 0,   6'h01, 0, 0, 0, 1,  0,  0);
        step(0, 0, 0, 6'h00, 1,   6'h01, 0, 0, 0, 0,  0,  0);
        step(0, 0, 1, 6'h00, 0,   6'h00, 0, 0, 0, 0,  0,  0);
        step(0, 0, 0, 6'h00, 1,   6'h01, 0, 0, 0, 1,  0,  0);
        step(0, 0, 0, 6'h00, 1,   6'h01, 0, 0, 0, 0,  0,  0);
        // legal loads drive z_run, including saturation of the narrow counter
        step(1, 0, 1, 6'h20, 0,   6'h20, 1, 0, 1, 0,  1,  1);
        step(0, 0, 1, 6'h10, 0,   6'h10, 1, 0, 1, 0,  2,  2);
        step(0, 0, 1, 6'h10, 0,   6'h10, 1, 0, 1, 0,  3,  3);
        step(0, 0, 1, 6'h10, 0,   6'h10, 1, 0, 1, 0,  3,  4);
        step(0, 0, 1, 6'h08, 0,   6'h08, 0, 0, 0, 0,  0,  0);
        // hold in E, saturation, freeze with en=0, exit to D
        step(1, 1, 0, 6'h00, 0,   6'h20, 1, 0, 0, 0,  1,  1);
        step(1, 1, 0, 6'h00, 0,   6'h04, 0, 0, 0, 0,  0,  0);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  1,  1);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  2,  2);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  3,  3);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  3,  4);
        step(1, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  3,  5);
        step(0, 1, 0, 6'h00, 0,   6'h10, 1, 0, 0, 0,  3,  5);
        step(0, 0, 0, 6'h00, 0,   6'h10, 1, 0, 1, 0,  3,  5);
        step(1, 0, 0, 6'h00, 0,   6'h08, 0, 0, 0, 0,  0,  0);
        // illegal y beats load; then build F with z_run=2 and err set
        step(0, 0, 1, 6'h00, 0,   6'h00, 0, 0, 0, 0,  0,  0);
        step(0, 0, 1, 6'h20, 0,   6'h01, 0, 0, 0, 1,  0,  0);
        step(0, 0, 1, 6'h20, 0,   6'h20, 1, 0, 1, 1,  1,  1);
        step(0, 0, 1, 6'h20, 0,   6'h20, 1, 0, 1, 1,  2,  2);

        // asynchronous reset between edges
        @(negedge clk);
        en = 1'b0; w = 1'b1; load = 1'b0; load_val = '0;
        #2 resetn = 1'b0;
        #1;
        r = '{y: 6'h01, z: 1'b0, y1: 1'b1, y3: 1'b0, err: 1'b0, zr2: 2'd0, zr8: 8'd0};
        chk_all(r);
        @(posedge clk);
        #1 chk_all(r);
        @(negedge clk);
        resetn = 1'b1;
        step(1, 1, 0, 6'h00, 0,   6'h02, 0, 0, 0, 0,  0,  0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
